// File: rtl/bnn_act_packer_if.sv
// Handshake bundle for the binary activation packer: neuron-side bit stream in,
// consumer-side word stream out, plus FIFO status.
interface bnn_act_packer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             bit_in;
  logic             bit_valid;
  logic             flush;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    fifo_count;
  logic             overflow;

  modport master (
    output bit_in, bit_valid, flush, out_ready,
    input  out_data, out_valid, fifo_count, overflow
  );

  modport slave (
    input  bit_in, bit_valid, flush, out_ready,
    output out_data, out_valid, fifo_count, overflow
  );
endinterface

// File: rtl/bnn_act_packer.sv
// Packs a stream of binary activations LSB-first into WIDTH-bit words and
// queues them in a first-word-fall-through FIFO with a sticky overflow flag.
module bnn_act_packer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  bnn_act_packer_if.slave  bus
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [WIDTH-1:0] packed_word;
  logic             push, pop, full, push_ok, out_valid;

  assign out_valid = (count_q != '0);

  always_comb begin
    packed_word = word_q;
    if (bus.bit_valid) packed_word[idx_q] = bus.bit_in;

    // A flush folds into the same push as a completing bit, so at most one word per cycle
    push    = (bus.bit_valid && (idx_q == IW'(WIDTH - 1)))
            || (bus.flush && (bus.bit_valid || (idx_q != '0)));
    pop     = out_valid && bus.out_ready;
    full    = (count_q == CW'(DEPTH));
    push_ok = push && (!full || pop);

    idx_d  = idx_q;
    word_d = word_q;
    if (push) begin
      idx_d  = '0;
      word_d = '0;
    end else if (bus.bit_valid) begin
      idx_d  = idx_q + IW'(1);
      word_d = packed_word;
    end

    wr_ptr_d   = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(push_ok) - CW'(pop);
    overflow_d = overflow_q | (push && !push_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      word_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      word_q     <= word_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is left unreset; out_data is masked whenever the FIFO is empty
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= packed_word;
  end

  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_bnn_act_packer.sv
// Randomized and directed bench for bnn_act_packer against a queue-based model
// of the packing and FIFO rules.
module tb_bnn_act_packer;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bnn_act_packer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  bnn_act_packer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] model_q [$];
  logic [WIDTH-1:0] model_part;
  int               model_idx;
  bit               model_ovf;

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkOutput();
    logic [WIDTH-1:0] exp_data;
    exp_data = (model_q.size() > 0) ? model_q[0] : '0;
    checkValue("out_valid", 32'(bus.out_valid), 32'(model_q.size() > 0));
    checkValue("out_data", 32'(bus.out_data), 32'(exp_data));
    checkValue("fifo_count", 32'(bus.fifo_count), 32'(model_q.size()));
    checkValue("overflow", 32'(bus.overflow), 32'(model_ovf));
  endtask

  task automatic modelReset();
    model_q.delete();
    model_part = '0;
    model_idx  = 0;
    model_ovf  = 1'b0;
  endtask

  task automatic modelStep(input bit bv, input bit bi, input bit fl, input bit rdy);
    bit               do_pop;
    bit               do_push;
    logic [WIDTH-1:0] w;
    do_pop  = (model_q.size() > 0) && rdy;
    do_push = 1'b0;
    w       = '0;
    if (bv) begin
      model_part[model_idx] = bi;
      model_idx++;
    end
    if (model_idx == WIDTH || (fl && model_idx > 0)) begin
      do_push    = 1'b1;
      w          = model_part;
      model_part = '0;
      model_idx  = 0;
    end
    if (do_pop) void'(model_q.pop_front());
    if (do_push) begin
      if (model_q.size() < DEPTH) model_q.push_back(w);
      else model_ovf = 1'b1;
    end
  endtask

  task automatic applyStimulus(input bit bv, input bit bi, input bit fl, input bit rdy);
    @(negedge clk);
    bus.bit_valid = bv;
    bus.bit_in    = bi;
    bus.flush     = fl;
    bus.out_ready = rdy;
    modelStep(bv, bi, fl, rdy);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic feedWord(input logic [WIDTH-1:0] w, input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, w[i], 1'b0, rdy);
  endtask

  task automatic idle(input bit rdy);
    applyStimulus(1'b0, 1'b0, 1'b0, rdy);
  endtask

  // Reset lands between clock edges so the async path is what clears the outputs
  task automatic asyncReset();
    #3;
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput();
    #2;
    rst = 1'b0;
  endtask

  initial begin
    int rdy_pct;
    bit bv, bi, fl, rdy;

    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    modelReset();
    #1;
    checkOutput();
    checkValue("reset out_data", 32'(bus.out_data), 32'h0);
    #13;
    rst = 1'b0;

    feedWord(8'h8D, WIDTH, 1'b1);
    checkValue("basic word", 32'(bus.out_data), 32'h8D);
    checkValue("basic valid", 32'(bus.out_valid), 32'h1);
    idle(1'b1);
    checkValue("basic drained", 32'(bus.fifo_count), 32'h0);

    feedWord(8'h07, 3, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkValue("flush word", 32'(bus.out_data), 32'h07);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    checkValue("idle flush count", 32'(bus.fifo_count), 32'h1);
    idle(1'b1);
    feedWord(8'h5A, WIDTH, 1'b0);
    checkValue("after flush word", 32'(bus.out_data), 32'h5A);
    idle(1'b1);

    for (int w = 0; w < 5; w++) feedWord(8'hFF, WIDTH, 1'b0);
    checkValue("ovf count", 32'(bus.fifo_count), 32'h4);
    checkValue("ovf flag", 32'(bus.overflow), 32'h1);
    for (int w = 0; w < 4; w++) begin
      checkValue("ovf drain", 32'(bus.out_data), 32'hFF);
      idle(1'b1);
    end
    checkValue("ovf drained valid", 32'(bus.out_valid), 32'h0);
    checkValue("ovf sticky", 32'(bus.overflow), 32'h1);

    feedWord(8'hA5, WIDTH, 1'b0);
    feedWord(8'h3C, WIDTH, 1'b0);
    feedWord(8'h07, 3, 1'b0);
    asyncReset();
    checkValue("arst valid", 32'(bus.out_valid), 32'h0);
    checkValue("arst count", 32'(bus.fifo_count), 32'h0);
    checkValue("arst overflow", 32'(bus.overflow), 32'h0);
    feedWord(8'h8D, WIDTH, 1'b0);
    checkValue("post-reset word", 32'(bus.out_data), 32'h8D);
    checkValue("post-reset count", 32'(bus.fifo_count), 32'h1);
    idle(1'b1);

    feedWord(8'h00, WIDTH - 1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
    checkValue("flush+bit count", 32'(bus.fifo_count), 32'h1);
    checkValue("flush+bit word", 32'(bus.out_data), 32'h80);
    idle(1'b1);

    feedWord(8'h11, WIDTH, 1'b0);
    feedWord(8'h22, WIDTH, 1'b0);
    feedWord(8'h33, WIDTH, 1'b0);
    feedWord(8'h44, WIDTH, 1'b0);
    feedWord(8'h55, WIDTH - 1, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    checkValue("full push+pop count", 32'(bus.fifo_count), 32'h4);
    checkValue("full push+pop ovf", 32'(bus.overflow), 32'h0);
    checkValue("full head 22", 32'(bus.out_data), 32'h22);
    idle(1'b1);
    checkValue("full head 33", 32'(bus.out_data), 32'h33);
    idle(1'b1);
    checkValue("full head 44", 32'(bus.out_data), 32'h44);
    idle(1'b1);
    checkValue("full head 55", 32'(bus.out_data), 32'h55);
    idle(1'b1);

    rdy_pct = 50;
    for (int cyc = 0; cyc < 1800; cyc++) begin
      if (cyc % 300 == 0) rdy_pct = (cyc / 300 % 3 == 0) ? 15 : ((cyc / 300 % 3 == 1) ? 50 : 90);
      if (cyc == 900) asyncReset();
      bv  = ($urandom_range(0, 9) < 7);
      bi  = $urandom_range(0, 1) == 1;
      fl  = ($urandom_range(0, 99) < 6);
      rdy = ($urandom_range(0, 99) < rdy_pct);
      applyStimulus(bv, bi, fl, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bnn_act_packer.md
BNN_ACT_PACKER -- requirements
Module: bnn_act_packer

Interface
REQ-001 Parameter: WIDTH, 8, bits per packed activation word.
REQ-002 Parameter: DEPTH, 4, output FIFO entries (power of two, at least 2).
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous and active-high.
REQ-005 Port: bit_in  input  1  binary neuron activation (neuron o_neuron output).
REQ-006 Port: bit_valid  input  1  bit_in is valid this cycle; no backpressure toward the neuron.
REQ-007 Port: flush  input  1  close the current partial word, zero-padded.
REQ-008 Port: out_data  output  WIDTH  head-of-FIFO activation word.
REQ-009 Port: out_valid  output  1  out_data holds a valid word.
REQ-010 Port: out_ready  input  1  consumer accepts the word; a pop occurs when out_valid and out_ready are both high.
REQ-011 Port: fifo_count  output  clog2(DEPTH)+1  number of occupied FIFO entries.
REQ-012 Port: overflow  output  1  sticky flag: a completed word was dropped.

Function
REQ-013 Each accepted bit (bit_valid=1) SHALL be packed LSB-first: the first bit of a word goes to bit 0 and the k-th bit goes to bit k-1.
REQ-014 A bit index counter 0..WIDTH-1 SHALL increment per accepted bit and wrap to 0 when a word completes.
REQ-015 On acceptance of the WIDTH-th bit, the assembled word SHALL be pushed into the FIFO at the same clock edge.
REQ-016 The FIFO SHALL be first-word-fall-through. A word pushed into an empty FIFO at edge N SHALL show out_valid=1 and the word on out_data after edge N (1-cycle latency from the last bit).
REQ-017 out_data SHALL be held stable while out_valid=1 and out_ready=0.
REQ-018 flush=1 with a partial word pending (index>0, or a bit accepted in the same cycle): push the word with unfilled high bits =0, then reset the index to 0.
REQ-019 flush and bit_valid in the same cycle: the bit SHALL be packed first, then the word pushed. Only one push occurs even if that bit completes the word.
REQ-020 flush with index=0 and bit_valid=0 SHALL have no effect.
REQ-021 Push while the FIFO is full and no pop in the same cycle: the word SHALL be dropped, the FIFO left unchanged, overflow set to 1, and the index reset to 0.
REQ-022 Simultaneous push and pop when full: both SHALL succeed; fifo_count stays at DEPTH; no overflow.
REQ-023 Simultaneous push and pop when not full and not empty: fifo_count unchanged, order preserved.
REQ-024 Pop when empty is impossible, because out_valid=0; out_ready is ignored.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH.
REQ-026 overflow SHALL remain 1 until reset.

Reset
REQ-027 rst=1 SHALL immediately clear the bit index, the partial word, the FIFO pointers, fifo_count=0, out_valid=0, out_data=0 and overflow=0, independent of clk.
REQ-028 Reset asserted mid-word or mid-transfer SHALL discard all pending bits and words. No push or pop occurs on the deassertion edge.
REQ-029 FIFO storage contents need not be reset, but out_data SHALL read 0 whenever out_valid=0.

Verification
REQ-030 Basic packing: 8 bits 1,0,1,1,0,0,0,1 with out_ready=1 -> out_data=8'h8D, out_valid high one cycle after the 8th bit, fifo_count returns to 0.
REQ-031 Flush: 3 bits 1,1,1 then flush -> out_data=8'h07; next word starts at bit 0.
REQ-032 Overflow: out_ready=0, 5 full words of 8'hFF -> fifo_count=4, overflow=1; draining yields exactly 4 words of 8'hFF.
REQ-033 Full push+pop: FIFO full, 8th bit arrives with out_ready=1 -> fifo_count stays 4, overflow stays 0, new word appears last.
REQ-034 Simultaneous flush and bit: 7 bits 0, then bit 1 with flush -> a single word 8'h80.
REQ-035 Async reset: assert rst mid-word with 2 words queued -> out_valid=0, fifo_count=0 and overflow=0 before the next clk edge; a fresh 8-bit sequence then packs correctly.
